// File: rtl/shift_counter_gen.sv
// Parametrised Johnson / one-hot ring counter with enable, direction, parallel load,
// decoded index, wrap pulse and illegal-state detection with optional self-correction.
module shift_counter_gen #(
    parameter int unsigned N            = 4,
    parameter int unsigned MODE         = 0,
    parameter int unsigned SELF_CORRECT = 1,
    localparam int unsigned States      = (MODE != 0) ? N : 2 * N,
    localparam int unsigned IW          = (States > 2) ? $clog2(States) : 1
) (
    input  logic          clk,
    input  logic          start,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [0:N-1]  load_val,
    output logic [0:N-1]  qout,
    output logic [IW-1:0] idx,
    output logic          wrap,
    output logic          illegal
);

    logic [0:N-1]  qout_q, qout_d;
    logic          wrap_q, wrap_d;
    logic [0:N-1]  rst_pat;
    logic [0:N-1]  up_val, down_val;
    logic [IW-1:0] idx_c;
    logic          illegal_c;
    int unsigned   ones_c;
    int unsigned   trans_c;
    int unsigned   pos_c;
    int unsigned   idx_int;

    // Decode: popcount, adjacent-bit transitions and position of the (last) set bit.
    always_comb begin
        ones_c  = 0;
        trans_c = 0;
        pos_c   = 0;
        idx_int = 0;
        for (int i = 0; i < int'(N); i++) begin
            ones_c = ones_c + 32'(qout_q[i]);
            if (qout_q[i]) begin
                pos_c = 32'(i);
            end
        end
        for (int i = 0; i < int'(N) - 1; i++) begin
            trans_c = trans_c + 32'(qout_q[i] ^ qout_q[i+1]);
        end
        if (MODE == 0) begin
            // A Johnson pattern is 1..10..0 or 0..01..1: at most one transition.
            illegal_c = (trans_c > 1);
            if (qout_q[0]) begin
                idx_int = ones_c;
            end else if (ones_c == 0) begin
                idx_int = 0;
            end else begin
                idx_int = 2 * N - ones_c;
            end
        end else begin
            illegal_c = (ones_c != 1);
            idx_int   = pos_c;
        end
        if (illegal_c) begin
            idx_int = 0;
        end
        idx_c = IW'(idx_int);
    end

    always_comb begin
        rst_pat = '0;
        if (MODE != 0) begin
            rst_pat[0] = 1'b1;
        end
        if (MODE == 0) begin
            up_val   = {~qout_q[N-1], qout_q[0:N-2]};
            down_val = {qout_q[1:N-1], ~qout_q[0]};
        end else begin
            up_val   = {qout_q[N-1], qout_q[0:N-2]};
            down_val = {qout_q[1:N-1], qout_q[0]};
        end
    end

    always_comb begin
        qout_d = qout_q;
        wrap_d = 1'b0;
        if (load) begin
            qout_d = load_val;
        end else if ((SELF_CORRECT != 0) && illegal_c) begin
            qout_d = rst_pat;
        end else if (en) begin
            qout_d = dir ? down_val : up_val;
            // Wrap only counts for steps taken from a legal state.
            wrap_d = !illegal_c && (dir ? (idx_c == '0) : (idx_c == IW'(States - 1)));
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            qout_q <= rst_pat;
            wrap_q <= 1'b0;
        end else begin
            qout_q <= qout_d;
            wrap_q <= wrap_d;
        end
    end

    assign qout    = qout_q;
    assign idx     = idx_c;
    assign wrap    = wrap_q;
    assign illegal = illegal_c;

endmodule
